// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the four slaves.
//
// Signals carry the same names the arbiter uses internally:
//   m0_* / m1_*   : master request (cyc, we, addr, sel, dat_w) and response
//                   (dat_r, ack, err) for port 0 (core) and port 1 (loader).
//   s_*           : shared slave bus (cyc, we, addr, sel, dat_w, one-hot stb)
//                   and per-slave ack.
//   ram_dat_r     : ram read data.
//   rx_dat_r      : uart RX read data (8 bit).
//
// Modports:
//   slave  : arbiter view. It serves the masters and drives the slave bus.
//   master : environment view (masters plus slaves), the mirror image.
interface bus_arbiter_if;
    logic        m0_cyc;
    logic        m0_we;
    logic [29:0] m0_addr;
    logic [3:0]  m0_sel;
    logic [31:0] m0_dat_w;
    logic [31:0] m0_dat_r;
    logic        m0_ack;
    logic        m0_err;

    logic        m1_cyc;
    logic        m1_we;
    logic [29:0] m1_addr;
    logic [3:0]  m1_sel;
    logic [31:0] m1_dat_w;
    logic [31:0] m1_dat_r;
    logic        m1_ack;
    logic        m1_err;

    logic        s_cyc;
    logic        s_we;
    logic [29:0] s_addr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w;
    logic [3:0]  s_stb;
    logic [3:0]  s_ack;
    logic [31:0] ram_dat_r;
    logic [7:0]  rx_dat_r;

    modport slave (
        input  m0_cyc, m0_we, m0_addr, m0_sel, m0_dat_w,
        output m0_dat_r, m0_ack, m0_err,
        input  m1_cyc, m1_we, m1_addr, m1_sel, m1_dat_w,
        output m1_dat_r, m1_ack, m1_err,
        output s_cyc, s_we, s_addr, s_sel, s_dat_w, s_stb,
        input  s_ack, ram_dat_r, rx_dat_r
    );

    modport master (
        output m0_cyc, m0_we, m0_addr, m0_sel, m0_dat_w,
        input  m0_dat_r, m0_ack, m0_err,
        output m1_cyc, m1_we, m1_addr, m1_sel, m1_dat_w,
        input  m1_dat_r, m1_ack, m1_err,
        input  s_cyc, s_we, s_addr, s_sel, s_dat_w, s_stb,
        output s_ack, ram_dat_r, rx_dat_r
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, four-slave bus arbiter.
//
// Arbitrates between master 0 (core) and master 1 (loader/DMA) round-robin,
// forwards the granted request onto the shared slave bus, decodes a one-hot
// slave strobe from the byte address and routes ack / read data back to the
// granted master. Unmapped accesses and slaves that fail to ack within
// TIMEOUT cycles are terminated with a one-cycle err pulse.
//
// Ports:
//   clk    : system clock, rising edge.
//   rst_n  : asynchronous active-low reset.
//   bus    : bus_arbiter_if.slave, master requests/responses and slave bus.
//
// Parameter:
//   TIMEOUT : BUSY cycles without ack before err is forced (2..255).
//
// The slave-bus outputs and the master responses are decoded
// combinationally from the registered state. The ack/err/dat_r path must
// reach the master in the same cycle as s_ack, and since the state register
// is reset asynchronously, every output drops to 0 as soon as rst_n goes low.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic        grant_r, grant_s;
    logic        last_r,  last_s;
    logic [7:0]  tcnt_r,  tcnt_s;

    logic        s_cyc_s;
    logic        s_we_s;
    logic [29:0] s_addr_s;
    logic [3:0]  s_sel_s;
    logic [31:0] s_dat_w_s;
    logic [3:0]  dec_s;
    logic [3:0]  s_stb_s;
    logic        ack_s;
    logic        err_s;
    logic [31:0] dat_r_s;

    // Word-address decode: ram is bytes 2048..3071, led/uart_tx/uart_rx are
    // bytes 1024/1028/1032.
    function automatic logic [3:0] decode(input logic [29:0] a);
        logic [3:0] d;
        case (a)
            30'd256: d = 4'b0010;
            30'd257: d = 4'b0100;
            30'd258: d = 4'b1000;
            default: begin
                if ((a >= 30'd512) && (a < 30'd768)) begin
                    d = 4'b0001;
                end else begin
                    d = 4'b0000;
                end
            end
        endcase
        return d;
    endfunction

    // State, grant, round-robin history and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            tcnt_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            tcnt_r  <= tcnt_s;
        end
    end

    // Shared slave bus: mirrors the granted master only while BUSY.
    always_comb begin
        s_cyc_s   = 1'b0;
        s_we_s    = 1'b0;
        s_addr_s  = 30'd0;
        s_sel_s   = 4'd0;
        s_dat_w_s = 32'd0;
        if (state_r == BUSY) begin
            if (grant_r) begin
                s_cyc_s   = bus.m1_cyc;
                s_we_s    = bus.m1_we;
                s_addr_s  = bus.m1_addr;
                s_sel_s   = bus.m1_sel;
                s_dat_w_s = bus.m1_dat_w;
            end else begin
                s_cyc_s   = bus.m0_cyc;
                s_we_s    = bus.m0_we;
                s_addr_s  = bus.m0_addr;
                s_sel_s   = bus.m0_sel;
                s_dat_w_s = bus.m0_dat_w;
            end
        end else begin
            s_cyc_s = 1'b0;
        end
    end

    // Strobe, ack, err and read-data selection. Ack takes priority over a
    // timeout that expires in the same cycle.
    always_comb begin
        dec_s   = decode(s_addr_s);
        s_stb_s = dec_s & {4{s_cyc_s}};
        ack_s   = |(bus.s_ack & s_stb_s);
        err_s   = s_cyc_s & ~ack_s & ((dec_s == 4'b0000) || (tcnt_r == TCNT_LAST));
        if (s_stb_s[0]) begin
            dat_r_s = bus.ram_dat_r;
        end else if (s_stb_s[3]) begin
            dat_r_s = {24'd0, bus.rx_dat_r};
        end else begin
            dat_r_s = 32'd0;
        end
    end

    // Drive the slave bus and return the response to the granted master only.
    always_comb begin
        bus.s_cyc    = s_cyc_s;
        bus.s_we     = s_we_s;
        bus.s_addr   = s_addr_s;
        bus.s_sel    = s_sel_s;
        bus.s_dat_w  = s_dat_w_s;
        bus.s_stb    = s_stb_s;
        bus.m0_ack   = 1'b0;
        bus.m0_err   = 1'b0;
        bus.m0_dat_r = 32'd0;
        bus.m1_ack   = 1'b0;
        bus.m1_err   = 1'b0;
        bus.m1_dat_r = 32'd0;
        if (grant_r) begin
            bus.m1_ack   = ack_s;
            bus.m1_err   = err_s;
            bus.m1_dat_r = dat_r_s;
        end else begin
            bus.m0_ack   = ack_s;
            bus.m0_err   = err_s;
            bus.m0_dat_r = dat_r_s;
        end
    end

    // Next-state logic: arbitration in IDLE, termination and timeout in BUSY.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        tcnt_s  = tcnt_r;
        case (state_r)
            IDLE: begin
                tcnt_s = 8'd0;
                if (bus.m0_cyc && bus.m1_cyc) begin
                    grant_s = ~last_r;
                    last_s  = ~last_r;
                    state_s = BUSY;
                end else if (bus.m0_cyc || bus.m1_cyc) begin
                    grant_s = bus.m1_cyc;
                    last_s  = bus.m1_cyc;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // A master that withdraws cyc ends the transfer silently.
                if (!s_cyc_s || ack_s || err_s) begin
                    state_s = IDLE;
                    tcnt_s  = 8'd0;
                end else begin
                    state_s = BUSY;
                    tcnt_s  = tcnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                tcnt_s  = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (TIMEOUT = 15).
// Inputs change 1 ns after a rising edge; outputs are sampled a further
// 1 ns later, well away from the next rising edge.
module tb_bus_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bus_arbiter_if bus();

    bus_arbiter #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_cyc = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 30'd0;
        bus.m0_sel = 4'hF; bus.m0_dat_w = 32'd0;
        bus.m1_cyc = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 30'd0;
        bus.m1_sel = 4'hF; bus.m1_dat_w = 32'd0;
        bus.s_ack = 4'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ram_dat_r = 32'hCAFE_F00D;
        bus.rx_dat_r  = 8'h5A;
        rst_n = 1'b0;
        bus.m0_cyc = 1'b1; bus.m0_addr = 30'd512; bus.s_ack = 4'hF;
        step(); step();
        #1;
        checks++;
        if (bus.s_cyc !== 1'b0 || bus.s_stb !== 4'd0 || bus.s_addr !== 30'd0) begin
            errors++;
            $display("FAIL reset_sbus: s_cyc=%b s_stb=%b s_addr=%0d, required 0/0000/0",
                     bus.s_cyc, bus.s_stb, bus.s_addr);
        end
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.m0_err !== 1'b0 || bus.m0_dat_r !== 32'd0) begin
            errors++;
            $display("FAIL reset_m0: ack=%b err=%b dat_r=%h, required 0/0/0",
                     bus.m0_ack, bus.m0_err, bus.m0_dat_r);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Both masters request continuously, every slave acks at once.
    task automatic test_round_robin();
        bus.m0_addr = 30'd512; bus.m1_addr = 30'd600;
        bus.ram_dat_r = 32'h1234_5678;
        bus.m0_cyc = 1'b1; bus.m1_cyc = 1'b1; bus.s_ack = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.s_cyc !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_%0d: s_cyc=%b, required 0", i, bus.s_cyc);
            end
            step();
            checks++;
            if ((i % 2) == 0) begin
                if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0 || bus.s_addr !== 30'd512 ||
                    bus.m0_dat_r !== 32'h1234_5678 || bus.m1_dat_r !== 32'd0) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: m0_ack=%b m1_ack=%b s_addr=%0d m0_dat_r=%h m1_dat_r=%h, required 1/0/512/12345678/0",
                             i, bus.m0_ack, bus.m1_ack, bus.s_addr, bus.m0_dat_r, bus.m1_dat_r);
                end
            end else begin
                if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0 || bus.s_addr !== 30'd600 ||
                    bus.m1_dat_r !== 32'h1234_5678 || bus.m0_dat_r !== 32'd0) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: m0_ack=%b m1_ack=%b s_addr=%0d m0_dat_r=%h m1_dat_r=%h, required 0/1/600/0/12345678",
                             i, bus.m0_ack, bus.m1_ack, bus.s_addr, bus.m0_dat_r, bus.m1_dat_r);
                end
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    // m0 reads byte 2048; ram acks one cycle after the strobe.
    task automatic test_ram_read();
        bus.m0_cyc = 1'b1; bus.m0_addr = 30'd512; bus.ram_dat_r = 32'hDEAD_BEEF;
        step();
        #1;
        checks++;
        if (bus.s_stb !== 4'b0001 || bus.s_cyc !== 1'b1 || bus.m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL ram_stb: s_stb=%b s_cyc=%b m0_ack=%b, required 0001/1/0",
                     bus.s_stb, bus.s_cyc, bus.m0_ack);
        end
        step();
        bus.s_ack = 4'b0001;
        #1;
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.m0_dat_r !== 32'hDEAD_BEEF || bus.m0_err !== 1'b0) begin
            errors++;
            $display("FAIL ram_ack: m0_ack=%b m0_dat_r=%h m0_err=%b, required 1/deadbeef/0",
                     bus.m0_ack, bus.m0_dat_r, bus.m0_err);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.s_cyc !== 1'b0 || bus.m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL ram_idle: s_cyc=%b m0_ack=%b, required 0/0", bus.s_cyc, bus.m0_ack);
        end
        step();
    endtask

    // m1 writes 0x41 to uart_tx; an ack from an unstrobed slave is ignored.
    task automatic test_uart_write();
        bus.m1_cyc = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 30'd257; bus.m1_dat_w = 32'h41;
        step();
        bus.s_ack = 4'b0001;
        #1;
        checks++;
        if (bus.s_stb !== 4'b0100 || bus.s_we !== 1'b1 || bus.s_dat_w !== 32'h41 ||
            bus.m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL tx_req: s_stb=%b s_we=%b s_dat_w=%h m1_ack=%b, required 0100/1/41/0",
                     bus.s_stb, bus.s_we, bus.s_dat_w, bus.m1_ack);
        end
        bus.s_ack = 4'b0100;
        #1;
        checks++;
        if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0 || bus.m1_err !== 1'b0) begin
            errors++;
            $display("FAIL tx_ack: m1_ack=%b m0_ack=%b m1_err=%b, required 1/0/0",
                     bus.m1_ack, bus.m0_ack, bus.m1_err);
        end
        step();
        idle_inputs();
        step();
    endtask

    // Unmapped byte address 0x100 gives a single err cycle.
    task automatic test_unmapped();
        bus.m0_cyc = 1'b1; bus.m0_addr = 30'd64;
        #1;
        checks++;
        if (bus.m0_err !== 1'b0) begin
            errors++;
            $display("FAIL unmap_pre: m0_err=%b, required 0", bus.m0_err);
        end
        step();
        checks++;
        if (bus.s_cyc !== 1'b1 || bus.s_stb !== 4'd0 || bus.m0_err !== 1'b1 ||
            bus.m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL unmap_err: s_cyc=%b s_stb=%b m0_err=%b m0_ack=%b, required 1/0000/1/0",
                     bus.s_cyc, bus.s_stb, bus.m0_err, bus.m0_ack);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.m0_err !== 1'b0 || bus.s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL unmap_post: m0_err=%b s_cyc=%b, required 0/0", bus.m0_err, bus.s_cyc);
        end
        step();
    endtask

    // led never acks: err in the 15th BUSY cycle. Then ack on the 15th wins.
    task automatic test_timeout();
        bus.m0_cyc = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 30'd256;
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++;
            if (bus.m0_err !== (k == 15) || bus.s_cyc !== 1'b1 || bus.m0_ack !== 1'b0) begin
                errors++;
                $display("FAIL tmo_cycle_%0d: m0_err=%b s_cyc=%b m0_ack=%b, required %b/1/0",
                         k, bus.m0_err, bus.s_cyc, bus.m0_ack, (k == 15));
            end
        end
        step();
        bus.m0_cyc = 1'b0;
        #1;
        checks++;
        if (bus.s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL tmo_idle: s_cyc=%b, required 0", bus.s_cyc);
        end
        step();
        bus.m0_cyc = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 15) bus.s_ack = 4'b0010;
            #1;
            checks++;
            if (bus.m0_err !== 1'b0 || bus.m0_ack !== (k == 15)) begin
                errors++;
                $display("FAIL tmo_ack_%0d: m0_err=%b m0_ack=%b, required 0/%b",
                         k, bus.m0_err, bus.m0_ack, (k == 15));
            end
        end
        step();
        idle_inputs();
        step();
    endtask

    // One master requesting continuously: one IDLE cycle between transfers.
    task automatic test_back_to_back();
        bus.m1_cyc = 1'b1; bus.m1_addr = 30'd258; bus.rx_dat_r = 8'hA5; bus.s_ack = 4'b1000;
        step();
        checks++;
        if (bus.m1_ack !== 1'b1 || bus.m1_dat_r !== 32'h0000_00A5 || bus.s_stb !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_first: m1_ack=%b m1_dat_r=%h s_stb=%b, required 1/000000a5/1000",
                     bus.m1_ack, bus.m1_dat_r, bus.s_stb);
        end
        step();
        checks++;
        if (bus.s_cyc !== 1'b0 || bus.m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: s_cyc=%b m1_ack=%b, required 0/0", bus.s_cyc, bus.m1_ack);
        end
        step();
        checks++;
        if (bus.m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: m1_ack=%b, required 1", bus.m1_ack);
        end
        step();
        idle_inputs();
        step();
    endtask

    // Reset in the middle of a BUSY transfer, then a tie goes to m0.
    task automatic test_reset_busy();
        bus.m1_cyc = 1'b1; bus.m1_addr = 30'd256;
        step();
        checks++;
        if (bus.s_cyc !== 1'b1 || bus.s_stb !== 4'b0010) begin
            errors++;
            $display("FAIL rstb_busy: s_cyc=%b s_stb=%b, required 1/0010", bus.s_cyc, bus.s_stb);
        end
        bus.s_ack = 4'hF;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_cyc !== 1'b0 || bus.s_stb !== 4'd0 || bus.m1_ack !== 1'b0 ||
            bus.m1_err !== 1'b0) begin
            errors++;
            $display("FAIL rstb_abort: s_cyc=%b s_stb=%b m1_ack=%b m1_err=%b, required 0/0000/0/0",
                     bus.s_cyc, bus.s_stb, bus.m1_ack, bus.m1_err);
        end
        bus.m0_cyc = 1'b1; bus.m0_addr = 30'd520; bus.m1_addr = 30'd530;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.s_addr !== 30'd520 || bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstb_tie: s_addr=%0d m0_ack=%b m1_ack=%b, required 520/1/0",
                     bus.s_addr, bus.m0_ack, bus.m1_ack);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_ram_read();
        test_uart_write();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, four-slave bus controller between the masters (furv core on port 0, a loader/DMA engine on port 1) and the memory-mapped slaves (ram, led, uart TX, uart RX). It arbitrates bus ownership round-robin and muxes the granted master's request onto the shared slave bus. It decodes the slave strobe from the byte address and routes ack/read data back. Unmapped accesses and hung slaves are terminated with a one-cycle error pulse so no master can stall the bus.

## Interface
Parameters:
- TIMEOUT, 15: cycles in BUSY without slave ack before err is forced (range 2..255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_cyc, m1_cyc  in  1  master requests a transfer; held until ack or err.
- m0_we, m1_we  in  1  write enable.
- m0_addr, m1_addr  in  30  word address (byte address = {addr, 2'b00}).
- m0_sel, m1_sel  in  4  byte lanes.
- m0_dat_w, m1_dat_w  in  32  write data.
- m0_dat_r, m1_dat_r  out  32  read data; valid when the matching ack is high.
- m0_ack, m1_ack  out  1  transfer complete.
- m0_err, m1_err  out  1  transfer aborted (unmapped or timeout).
- s_cyc, s_we  out  1  shared slave-bus cycle and write enable.
- s_addr  out  30; s_sel  out  4; s_dat_w  out  32: granted master's request.
- s_stb  out  4  one-hot strobe: [0] ram, [1] led, [2] uart_tx, [3] uart_rx.
- s_ack  in  4  per-slave ack, same bit order.
- ram_dat_r  in  32; rx_dat_r  in  8: slave read data.

## Operation
- States: IDLE, BUSY. Registers: grant (0/1), last (0/1), tcnt (8 bit).
- IDLE: all s_* outputs 0. If any mN_cyc is high, go to BUSY next edge.
  - Sole requester: grant goes to that master.
  - Both requesting: grant = ~last.
  - last <= grant.
- BUSY: s_cyc, s_we, s_addr, s_sel and s_dat_w mirror the granted master. The non-granted master sees ack=err=0 and dat_r=0.
- Decode on byte address B = {s_addr, 2'b00}; decode is combinational from s_addr:
  - ram: 2048 <= B < 3072.
  - led: B == 1024.
  - uart_tx: B == 1028.
  - uart_rx: B == 1032.
  - Anything else is unmapped.
- s_stb is the decode result ANDed with s_cyc.
- Ack routing: m_ack(granted) = |(s_ack & s_stb). Acks from slaves that are not strobed are ignored.
- Read data: ram_dat_r if ram is strobed; {24'b0, rx_dat_r} if uart_rx is strobed; otherwise 0.
- Error cases (each gives a one-cycle m_err on the granted master, and ack stays 0):
  - Unmapped: err in the first BUSY cycle; s_cyc is still driven, but no stb is asserted.
  - Timeout: tcnt increments each BUSY cycle without ack; err fires when tcnt == TIMEOUT-1.
- Leaving BUSY: on ack or err, the next state is IDLE and tcnt <= 0. If the granted master drops cyc without ack, return to IDLE silently.
- Reset (async assert, sync-free): state=IDLE, grant=0, last=1 (m0 wins the first tie), tcnt=0. All outputs are 0 while rst_n is low. Reset during BUSY abandons the transfer and gives no ack or err.

## Timing
- Arbitration latency: 1 cycle. cyc rises at edge t (in IDLE), and s_cyc/s_stb are high from t+1.
- Ack/err/dat_r path from slave to master is combinational, in the same cycle as s_ack.
- Minimum transfer: 2 cycles (grant + single-cycle slave ack). Back-to-back transfers from one master have one IDLE cycle between them.
- Round-robin guarantee: with both masters requesting continuously, grants alternate strictly (0,1,0,1…).
- A request arriving during BUSY waits. Worst-case wait = TIMEOUT+2 cycles.
- s_ack high on a strobed slave in the same cycle tcnt reaches TIMEOUT-1: ack wins and err stays 0.

## Test plan
- m0 reads B=2048; ram acks 1 cycle after s_stb with 0xDEADBEEF -> s_stb=0001 at t+1, m0_ack and m0_dat_r=0xDEADBEEF at t+2, IDLE at t+3.
- m0 and m1 both assert cyc at the same edge, every slave acks immediately, 4 transfers -> grant order 0,1,0,1; the waiting master sees no ack.
- m1 writes B=1028, data 0x41 -> s_stb=0100, s_we=1, s_dat_w=0x41; m1_ack when s_ack[2]=1; m0_ack stays 0.
- m0 reads B=0x100 (unmapped) -> s_stb=0000, m0_err high exactly one cycle at t+1, m0_ack=0.
- m0 writes B=1024 and led never acks, TIMEOUT=15 -> m0_err pulses 15 cycles after s_cyc rises, then IDLE. Repeat with s_ack on the 15th cycle -> ack, no err.
- rst_n low mid-BUSY -> all outputs 0 immediately. After release, a simultaneous request is granted to m0.
